weed_nav_ctrl: RTL and testbench
================================

Name: weed_nav_ctrl

Overview:
- Parametrised successor to the single-sensor weed robot controller.
- Drives a serpentine row sweep: forward for a row, then a turn, alternating right/left, for a fixed number of rows.
- Monitors N plant-sensor channels with per-channel debounce, stops to spray on detection, and lights per-channel LEDs during the spray.
- Sits between the sensor front-end and the motor/spray driver block.

Parameters:
- N_CH, 4, number of plant-sensor channels (1..16).
- ROW_LEN, 16, forward-motion cycles per row.
- TURN_CYC, 4, cycles spent in each end-of-row turn.
- NUM_ROWS, 2, rows per sweep (>=1).
- DEB_CYC, 3, consecutive high cycles before a channel counts as detected (>=1).
- SPRAY_CYC, 5, stop-and-spray dwell cycles (>=1).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- plant  in  N_CH  raw plant-sensor inputs, one per channel.
- front  out  1  move-forward command.
- left  out  1  turn-left command.
- right  out  1  turn-right command.
- stop  out  1  halt command.
- led  out  N_CH  spray/indicator per channel.
- row_count  out  $clog2(NUM_ROWS+1)  completed rows.
- done  out  1  sweep complete.
- busy  out  1  high in FWD, TURN, SPRAY.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all counters cleared; all channels armed.
  - Outputs: stop=1, front=left=right=0, led=0, row_count=0, done=0, busy=0.
- Outputs are registered; exactly one of front/left/right/stop is high every cycle.
- States:
  - IDLE: stop=1. enable=1 -> FWD, step and row counters cleared.
  - FWD: front=1; step counter increments each cycle. Any debounced detection -> SPRAY, with priority over end-of-row. Step counter reaching ROW_LEN-1 with no detection -> TURN.
  - SPRAY: stop=1. led[i]=1 for every channel detected on entry; led is frozen for the whole dwell. Step counter frozen. After SPRAY_CYC cycles: led cleared; return to FWD, or to TURN if the step counter had already reached ROW_LEN-1.
  - TURN: right=1 when row_count is even, left=1 when odd; lasts TURN_CYC cycles. On exit: row_count increments, step counter clears. If row_count becomes NUM_ROWS -> DONE, else -> FWD.
  - DONE: stop=1, done=1, held while enable=1. enable=0 -> IDLE (done clears, row_count clears).
- Pause: enable=0 in FWD or TURN -> outputs stop=1, all counters and state frozen; enable=1 resumes next cycle. In SPRAY, enable is ignored until the dwell completes.
- Debounce, per channel:
  - Counter saturates at DEB_CYC and clears whenever plant[i]=0.
  - A detection is plant[i] high for DEB_CYC consecutive cycles while the channel is armed.
  - Counters are active only in FWD; they are held cleared in all other states.
  - A channel that triggers a spray disarms and re-arms only after plant[i] is seen low. This prevents re-spraying the same weed.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit; no wrap-around is reachable.
- Latency: debounced detection to stop=1 is 1 cycle after the DEB_CYC-th high sample.

Optional Feature:
- Macro: WEED_OBSTACLE_EN.
- When defined:
  - Adds input port obstacle (1 bit).
  - obstacle=1 in FWD or TURN forces stop=1 and freezes all counters, as for a pause.
  - A new output obstacle_hit (1 bit) is set and stays sticky until the IDLE state or reset.
  - Obstacle has priority over detection in the same cycle.
- When undefined: no obstacle port and no obstacle_hit output; behaviour as above.

Test Plan:
- Clean sweep: defaults, enable=1, plant=0 -> front for 16 cycles, right for 4, front 16, left 4. Then done=1, stop=1, row_count=2.
- Debounce: plant[2] high for 2 cycles then low -> no spray. plant[2] high 3 cycles -> stop=1 next cycle, led=4'b0100 for 5 cycles, then front resumes with the step count preserved.
- Re-arm: plant[2] held high through a spray -> no second spray. Drop it for 1 cycle, raise for 3 -> second spray.
- Simultaneous: plant[0] and plant[3] debounce on the final FWD step -> led=4'b1001 for 5 cycles, then TURN right, never FWD.
- Pause and reset: enable=0 mid-row at step 7 -> stop=1 with counters frozen; re-enable -> 9 more front cycles. Assert reset mid-SPRAY -> outputs return to reset values immediately (asynchronously).
- WEED_OBSTACLE_EN: obstacle=1 for 3 cycles mid-FWD -> stop=1 and obstacle_hit=1; row completes 3 cycles late.

Source files
------------

// File: rtl/weed_nav_ctrl.sv
// weed_nav_ctrl: serpentine row-sweep controller for the weed robot.
// Drives forward/turn/stop commands, and debounces N_CH plant sensors. A detection
// in forward motion stops the robot for a spray dwell and lights the LEDs of the
// channels that fired.
// Optional feature macro: WEED_OBSTACLE_EN adds the obstacle input and the sticky
// obstacle_hit output. An obstacle pauses FWD/TURN and wins over a detection.
// Interface contract: there is no valid/ready handshake. enable is a level-sensitive
// run request that is sampled on every rising clock edge. All command outputs are
// registered, and exactly one of front/left/right/stop is high in every cycle.
module weed_nav_ctrl #(
  parameter int N_CH      = 4,
  parameter int ROW_LEN   = 16,
  parameter int TURN_CYC  = 4,
  parameter int NUM_ROWS  = 2,
  parameter int DEB_CYC   = 3,
  parameter int SPRAY_CYC = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
`ifdef WEED_OBSTACLE_EN
  input  logic                            obstacle,
  output logic                            obstacle_hit,
`endif
  input  logic [N_CH-1:0]                 plant,
  output logic                            front,
  output logic                            left,
  output logic                            right,
  output logic                            stop,
  output logic [N_CH-1:0]                 led,
  output logic [$clog2(NUM_ROWS+1)-1:0]   row_count,
  output logic                            done,
  output logic                            busy,
  output logic [2:0]                      dbg_state
);

  localparam int SW = (ROW_LEN > 1)   ? $clog2(ROW_LEN)   : 1;
  localparam int TW = (TURN_CYC > 1)  ? $clog2(TURN_CYC)  : 1;
  localparam int PW = (SPRAY_CYC > 1) ? $clog2(SPRAY_CYC) : 1;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RW = $clog2(NUM_ROWS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FWD   = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_SPRAY = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      st;
  logic [SW-1:0]   step;
  logic [TW-1:0]   tcnt;
  logic [PW-1:0]   scnt;
  logic            at_end;
  logic [DW-1:0]   deb [N_CH];
  logic [N_CH-1:0] armed;
  logic [N_CH-1:0] hit;
  logic            hold;
  logic            run_fwd;

  assign dbg_state = st;

`ifdef WEED_OBSTACLE_EN
  assign hold = !enable || obstacle;
`else
  assign hold = !enable;
`endif
  assign run_fwd = (st == S_FWD) && !hold;

  // A channel fires on its DEB_CYC-th consecutive high sample while armed.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++)
      hit[i] = run_fwd && armed[i] && plant[i] && (deb[i] == DW'(DEB_CYC - 1));
  end

  // Per-channel debounce counters and arm flags. Counters run only in
  // unpaused FWD. Arming is restored whenever the sensor reads low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed <= '1;
      for (int i = 0; i < N_CH; i++) deb[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!plant[i]) armed[i] <= 1'b1;
        else if (hit[i]) armed[i] <= 1'b0;
        if (st != S_FWD) deb[i] <= '0;
        else if (!hold) begin
          if (!plant[i]) deb[i] <= '0;
          else if (deb[i] != DW'(DEB_CYC)) deb[i] <= deb[i] + 1'b1;
        end
      end
    end
  end

  // Sweep FSM with registered command outputs, ordered {front, left, right, stop}.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st        <= S_IDLE;
      step      <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      at_end    <= 1'b0;
      {front, left, right, stop} <= 4'b0001;
      led       <= '0;
      row_count <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          done      <= 1'b0;
          row_count <= '0;
          if (enable) begin
            st   <= S_FWD;
            step <= '0;
            busy <= 1'b1;
            {front, left, right, stop} <= 4'b1000;
          end else begin
            busy <= 1'b0;
            {front, left, right, stop} <= 4'b0001;
          end
        end
        S_FWD: begin
          if (hold) begin
            {front, left, right, stop} <= 4'b0001;
          end else if (|hit) begin
            st     <= S_SPRAY;
            led    <= hit;
            scnt   <= '0;
            at_end <= (step == SW'(ROW_LEN - 1));
            {front, left, right, stop} <= 4'b0001;
          end else if (step == SW'(ROW_LEN - 1)) begin
            st   <= S_TURN;
            tcnt <= '0;
            {front, left, right, stop} <= {1'b0, row_count[0], ~row_count[0], 1'b0};
          end else begin
            step <= step + 1'b1;
            {front, left, right, stop} <= 4'b1000;
          end
        end
        S_TURN: begin
          if (hold) begin
            {front, left, right, stop} <= 4'b0001;
          end else if (tcnt == TW'(TURN_CYC - 1)) begin
            row_count <= row_count + 1'b1;
            step      <= '0;
            if (row_count + 1'b1 == RW'(NUM_ROWS)) begin
              st   <= S_DONE;
              done <= 1'b1;
              busy <= 1'b0;
              {front, left, right, stop} <= 4'b0001;
            end else begin
              st <= S_FWD;
              {front, left, right, stop} <= 4'b1000;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            {front, left, right, stop} <= {1'b0, row_count[0], ~row_count[0], 1'b0};
          end
        end
        S_SPRAY: begin
          // enable is deliberately ignored until the dwell completes.
          if (scnt == PW'(SPRAY_CYC - 1)) begin
            led <= '0;
            if (at_end) begin
              st   <= S_TURN;
              tcnt <= '0;
              {front, left, right, stop} <= {1'b0, row_count[0], ~row_count[0], 1'b0};
            end else begin
              st <= S_FWD;
              {front, left, right, stop} <= 4'b1000;
            end
          end else begin
            scnt <= scnt + 1'b1;
            {front, left, right, stop} <= 4'b0001;
          end
        end
        S_DONE: begin
          {front, left, right, stop} <= 4'b0001;
          if (!enable) begin
            st        <= S_IDLE;
            done      <= 1'b0;
            row_count <= '0;
          end
        end
        default: begin
          st <= S_IDLE;
          {front, left, right, stop} <= 4'b0001;
        end
      endcase
    end
  end

`ifdef WEED_OBSTACLE_EN
  // Sticky record that an obstacle interrupted motion. It clears in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) obstacle_hit <= 1'b0;
    else if (st == S_IDLE) obstacle_hit <= 1'b0;
    else if (obstacle && (st == S_FWD || st == S_TURN)) obstacle_hit <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_weed_nav_ctrl.sv
// tb_weed_nav_ctrl: scoreboard bench for weed_nav_ctrl with default parameters.
// Each driven cycle pushes the expected registered outputs.
// The bench then pops them after the next rising edge.
module tb_weed_nav_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] plant;
  logic       obstacle;
  logic       front, left, right, stop, done, busy;
  logic [3:0] led;
  logic [1:0] row_count;
  logic [2:0] dbg_state;
`ifdef WEED_OBSTACLE_EN
  logic       obstacle_hit;
`endif

  localparam logic [3:0] C_F = 4'b1000;
  localparam logic [3:0] C_L = 4'b0100;
  localparam logic [3:0] C_R = 4'b0010;
  localparam logic [3:0] C_S = 4'b0001;

  logic [11:0] exp_q[$];
  int checks;
  int errors;

  weed_nav_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
`ifdef WEED_OBSTACLE_EN
    .obstacle     (obstacle),
    .obstacle_hit (obstacle_hit),
`endif
    .plant     (plant),
    .front     (front),
    .left      (left),
    .right     (right),
    .stop      (stop),
    .led       (led),
    .row_count (row_count),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] observed();
    return {front, left, right, stop, done, busy, led, row_count};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver task: it applies the inputs for n cycles and queues the expected outputs.
  // After each edge it pops one expected value and compares it.
  task automatic run(input int n, input logic en, input logic [3:0] pl,
                     input logic [3:0] cmd, input logic [3:0] ld, input logic [1:0] rw,
                     input logic dn, input logic bz, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      enable = en;
      plant  = pl;
      exp_q.push_back({cmd, dn, bz, ld, rw});
      @(posedge clock);
      #1;
      check_eq(tag, observed(), exp_q.pop_front());
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    plant    = 4'b0;
    obstacle = 1'b0;
    #12;
    check_eq("reset", observed(), {C_S, 1'b0, 1'b0, 4'b0, 2'd0});
    @(negedge clock);
    reset = 1'b1;
    run(2, 0, 4'b0, C_S, 4'b0, 2'd0, 0, 0, "idle");

    // Clean sweep
    run(16, 1, 4'b0, C_F, 4'b0, 2'd0, 0, 1, "a_fwd0");
    run(4,  1, 4'b0, C_R, 4'b0, 2'd0, 0, 1, "a_right");
    run(16, 1, 4'b0, C_F, 4'b0, 2'd1, 0, 1, "a_fwd1");
    run(4,  1, 4'b0, C_L, 4'b0, 2'd1, 0, 1, "a_left");
    run(3,  1, 4'b0, C_S, 4'b0, 2'd2, 1, 0, "a_done");
    run(1,  0, 4'b0, C_S, 4'b0, 2'd0, 0, 0, "a_idle");

    // Debounce: a short pulse is ignored, and three highs cause a spray
    run(1,  1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "b_start");
    run(2,  1, 4'b0100, C_F, 4'b0,    2'd0, 0, 1, "b_short");
    run(1,  1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "b_low");
    run(2,  1, 4'b0100, C_F, 4'b0,    2'd0, 0, 1, "b_deb");
    run(1,  1, 4'b0100, C_S, 4'b0100, 2'd0, 0, 1, "b_spray_entry");
    run(4,  1, 4'b0,    C_S, 4'b0100, 2'd0, 0, 1, "b_spray");
    run(11, 1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "b_resume");
    run(4,  1, 4'b0,    C_R, 4'b0,    2'd0, 0, 1, "b_right");
    run(1,  1, 4'b0,    C_F, 4'b0,    2'd1, 0, 1, "c_start");

    // Re-arm: a held sensor does not spray twice, and a low sample re-arms it
    run(2,  1, 4'b0100, C_F, 4'b0,    2'd1, 0, 1, "c_deb");
    run(5,  1, 4'b0100, C_S, 4'b0100, 2'd1, 0, 1, "c_spray1");
    run(4,  1, 4'b0100, C_F, 4'b0,    2'd1, 0, 1, "c_held_no_spray");
    run(1,  1, 4'b0,    C_F, 4'b0,    2'd1, 0, 1, "c_drop");
    run(2,  1, 4'b0100, C_F, 4'b0,    2'd1, 0, 1, "c_deb2");
    run(1,  1, 4'b0100, C_S, 4'b0100, 2'd1, 0, 1, "c_spray2_entry");
    run(4,  1, 4'b0,    C_S, 4'b0100, 2'd1, 0, 1, "c_spray2");
    run(8,  1, 4'b0,    C_F, 4'b0,    2'd1, 0, 1, "c_resume");
    run(4,  1, 4'b0,    C_L, 4'b0,    2'd1, 0, 1, "c_left");
    run(1,  1, 4'b0,    C_S, 4'b0,    2'd2, 1, 0, "c_done");
    run(1,  0, 4'b0,    C_S, 4'b0,    2'd0, 0, 0, "c_idle");

    // Simultaneous detection on the last step leads to a spray and then a turn
    run(14, 1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "d_fwd");
    run(2,  1, 4'b1001, C_F, 4'b0,    2'd0, 0, 1, "d_deb");
    run(1,  1, 4'b1001, C_S, 4'b1001, 2'd0, 0, 1, "d_spray_entry");
    run(4,  1, 4'b0,    C_S, 4'b1001, 2'd0, 0, 1, "d_spray");
    run(4,  1, 4'b0,    C_R, 4'b0,    2'd0, 0, 1, "d_right");

    // Pause after seven front cycles, then nine more after re-enable
    run(7,  1, 4'b0,    C_F, 4'b0,    2'd1, 0, 1, "e_fwd");
    run(3,  0, 4'b0,    C_S, 4'b0,    2'd1, 0, 1, "e_pause");
    run(9,  1, 4'b0,    C_F, 4'b0,    2'd1, 0, 1, "e_resume");
    run(4,  1, 4'b0,    C_L, 4'b0,    2'd1, 0, 1, "e_left");
    run(1,  1, 4'b0,    C_S, 4'b0,    2'd2, 1, 0, "e_done");
    run(1,  0, 4'b0,    C_S, 4'b0,    2'd0, 0, 0, "e_idle");

    // An asynchronous reset in the middle of a spray
    run(1,  1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "f_start");
    run(2,  1, 4'b0001, C_F, 4'b0,    2'd0, 0, 1, "f_deb");
    run(1,  1, 4'b0001, C_S, 4'b0001, 2'd0, 0, 1, "f_spray_entry");
    run(1,  1, 4'b0,    C_S, 4'b0001, 2'd0, 0, 1, "f_spray");
    #2;
    reset = 1'b0;
    #1;
    check_eq("f_async_reset", observed(), {C_S, 1'b0, 1'b0, 4'b0, 2'd0});
    @(negedge clock);
    enable = 1'b0;
    reset  = 1'b1;
    run(1,  0, 4'b0,    C_S, 4'b0,    2'd0, 0, 0, "f_post_reset");

`ifdef WEED_OBSTACLE_EN
    // An obstacle in the middle of FWD stalls the row for three cycles
    run(5,  1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "g_fwd");
    obstacle = 1'b1;
    run(3,  1, 4'b0111, C_S, 4'b0,    2'd0, 0, 1, "g_obstacle");
    check_eq("g_hit", {11'b0, obstacle_hit}, 12'd1);
    obstacle = 1'b0;
    run(11, 1, 4'b0,    C_F, 4'b0,    2'd0, 0, 1, "g_resume");
    run(4,  1, 4'b0,    C_R, 4'b0,    2'd0, 0, 1, "g_right");
    check_eq("g_hit_sticky", {11'b0, obstacle_hit}, 12'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
